bin_bcd_conv: RTL and testbench

Parametrised sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock. It is the generalised successor of the display-path decimal splitter. It takes any binary width and digit count, uses valid/ready handshakes on both sides, and adds overflow saturation and a significant-digit count for leading-zero blanking. It sits between score/timer/money counters and the seven-segment or VGA digit renderers.

---
 rtl/bin_bcd_pkg.sv | 26 ++
 rtl/bin_bcd_conv_digit_adj.sv | 9 +
 rtl/bin_bcd_conv.sv | 105 ++++++++++
 tb/tb_bin_bcd_conv.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/bin_bcd_pkg.sv
// Shared types, constants and helpers for the binary-to-BCD converter.
package bin_bcd_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam int NIB_W      = 4;
    localparam int MAX_DIGITS = 16;

    localparam logic [NIB_W*MAX_DIGITS-1:0] ALL_NINES = {MAX_DIGITS{4'h9}};

    // 1 + index of the highest nonzero nibble among the low `digits`; 1 for zero.
    function automatic int sig_digits(
        input logic [NIB_W*MAX_DIGITS-1:0] bcd,
        input int                          digits
    );
        int n;
        n = 1;
        for (int k = 0; k < MAX_DIGITS; k++) begin
            if (k < digits && bcd[NIB_W*k +: NIB_W] != '0) begin
                n = k + 1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/bin_bcd_conv_digit_adj.sv
// Double-dabble nibble correction: add 3 to any digit of 5 or more.
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_bcd_conv.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per clock,
// with overflow saturation and significant-digit count.
module bin_bcd_conv
    import bin_bcd_pkg::*;
#(
    parameter int BIN_W  = 12,
    parameter int DIGITS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [BIN_W-1:0]             in_bin,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NIB_W*DIGITS-1:0]      out_bcd,
    output logic [$clog2(DIGITS+1)-1:0]  out_ndig,
    output logic                         out_ovf
);

    localparam int BCD_W  = NIB_W * DIGITS;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int CNT_W  = $clog2(BIN_W + 1);
    localparam int NDIG_W = $clog2(DIGITS + 1);
    localparam int PAD_W  = NIB_W * MAX_DIGITS;

    state_t              state;
    logic [WORK_W-1:0]   work;
    logic [CNT_W-1:0]    cnt;
    logic                ovf;

    logic [BCD_W-1:0]    adj_bcd;
    logic [WORK_W-1:0]   adj_work;
    logic [WORK_W-1:0]   nxt_work;
    logic [BCD_W-1:0]    fin_bcd;
    logic [PAD_W-1:0]    fin_pad;
    logic                fin_ovf;
    logic [NDIG_W-1:0]   fin_ndig;

    for (genvar k = 0; k < DIGITS; k++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (work[BIN_W + NIB_W*k +: NIB_W]),
            .dout (adj_bcd[NIB_W*k +: NIB_W])
        );
    end

    assign adj_work = {adj_bcd, work[BIN_W-1:0]};
    assign nxt_work = {adj_work[WORK_W-2:0], 1'b0};
    assign fin_bcd  = nxt_work[WORK_W-1 -: BCD_W];
    assign fin_pad  = PAD_W'(fin_bcd);
    // The bit leaving the top nibble is a carry past the last digit.
    assign fin_ovf  = ovf | adj_work[WORK_W-1];
    assign fin_ndig = NDIG_W'(sig_digits(fin_pad, DIGITS));

    assign in_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            work      <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_bcd   <= '0;
            out_ndig  <= NDIG_W'(1);
            out_ovf   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        work  <= {{BCD_W{1'b0}}, in_bin};
                        cnt   <= CNT_W'(BIN_W);
                        ovf   <= 1'b0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    work <= nxt_work;
                    cnt  <= cnt - CNT_W'(1);
                    ovf  <= fin_ovf;
                    if (cnt == CNT_W'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_ovf   <= fin_ovf;
                        if (fin_ovf) begin
                            out_bcd  <= ALL_NINES[BCD_W-1:0];
                            out_ndig <= NDIG_W'(DIGITS);
                        end else begin
                            out_bcd  <= fin_bcd;
                            out_ndig <= fin_ndig;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_bcd_conv.sv
// Directed bench for bin_bcd_conv across three parameter sets.
module tb_bin_bcd_conv;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // u0: BIN_W=12, DIGITS=4
    logic        iv0 = 0, ir0, ov0, or0 = 1, ovf0;
    logic [11:0] ib0 = '0;
    logic [15:0] bcd0;
    logic [2:0]  nd0;
    // u1: BIN_W=12, DIGITS=3
    logic        iv1 = 0, ir1, ov1, or1 = 1, ovf1;
    logic [11:0] ib1 = '0;
    logic [11:0] bcd1;
    logic [1:0]  nd1;
    // u2: BIN_W=16, DIGITS=5
    logic        iv2 = 0, ir2, ov2, or2 = 1, ovf2;
    logic [15:0] ib2 = '0;
    logic [19:0] bcd2;
    logic [2:0]  nd2;

    bin_bcd_conv #(.BIN_W(12), .DIGITS(4)) u0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .in_bin(ib0),
        .out_valid(ov0), .out_ready(or0), .out_bcd(bcd0), .out_ndig(nd0),
        .out_ovf(ovf0)
    );
    bin_bcd_conv #(.BIN_W(12), .DIGITS(3)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_bin(ib1),
        .out_valid(ov1), .out_ready(or1), .out_bcd(bcd1), .out_ndig(nd1),
        .out_ovf(ovf1)
    );
    bin_bcd_conv #(.BIN_W(16), .DIGITS(5)) u2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .in_bin(ib2),
        .out_valid(ov2), .out_ready(or2), .out_bcd(bcd2), .out_ndig(nd2),
        .out_ovf(ovf2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic conv0(input logic [11:0] v, input logic [15:0] eb,
                         input logic [2:0] en, input logic eo);
        int n;
        n = 0;
        while (!ir0 && n < 64) begin tick(); n++; end
        chk("u0_ready", 32'(ir0), 1);
        iv0 = 1; ib0 = v;
        tick();
        iv0 = 0;
        n = 0;
        while (!ov0 && n < 64) begin tick(); n++; end
        chk("u0_latency", n, 12);
        chk("u0_bcd", 32'(bcd0), 32'(eb));
        chk("u0_ndig", 32'(nd0), 32'(en));
        chk("u0_ovf", 32'(ovf0), 32'(eo));
        if (or0) begin
            tick();
            chk("u0_valid_drop", 32'(ov0), 0);
        end
    endtask

    task automatic conv1(input logic [11:0] v, input logic [11:0] eb,
                         input logic [1:0] en, input logic eo);
        int n;
        n = 0;
        while (!ir1 && n < 64) begin tick(); n++; end
        iv1 = 1; ib1 = v;
        tick();
        iv1 = 0;
        n = 0;
        while (!ov1 && n < 64) begin tick(); n++; end
        chk("u1_latency", n, 12);
        chk("u1_bcd", 32'(bcd1), 32'(eb));
        chk("u1_ndig", 32'(nd1), 32'(en));
        chk("u1_ovf", 32'(ovf1), 32'(eo));
        tick();
    endtask

    task automatic conv2(input logic [15:0] v, input logic [19:0] eb,
                         input logic [2:0] en);
        int n;
        n = 0;
        while (!ir2 && n < 64) begin tick(); n++; end
        iv2 = 1; ib2 = v;
        tick();
        iv2 = 0;
        n = 0;
        while (!ov2 && n < 64) begin tick(); n++; end
        chk("u2_latency", n, 16);
        chk("u2_bcd", 32'(bcd2), 32'(eb));
        chk("u2_ndig", 32'(nd2), 32'(en));
        chk("u2_ovf", 32'(ovf2), 0);
    endtask

    initial begin
        int n;
        rst = 1;
        tick();
        tick();
        chk("rst_in_ready", 32'(ir0), 0);
        chk("rst_valid", 32'(ov0), 0);
        chk("rst_bcd", 32'(bcd0), 0);
        chk("rst_ndig", 32'(nd0), 1);
        chk("rst_ovf", 32'(ovf0), 0);
        rst = 0;
        tick();
        chk("rel_in_ready", 32'(ir0), 1);

        conv0(12'd4095, 16'h4095, 3'd4, 1'b0);
        conv0(12'd0,    16'h0000, 3'd1, 1'b0);
        conv0(12'd7,    16'h0007, 3'd1, 1'b0);
        conv0(12'd100,  16'h0100, 3'd3, 1'b0);

        or0 = 0;
        conv0(12'd321, 16'h0321, 3'd3, 1'b0);
        iv0 = 1; ib0 = 12'd5;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", 32'(ov0), 1);
            chk("bp_bcd", 32'(bcd0), 32'h0321);
            chk("bp_in_ready", 32'(ir0), 0);
        end
        iv0 = 0;
        or0 = 1;
        tick();
        chk("bp_release_valid", 32'(ov0), 0);
        chk("bp_hold_bcd", 32'(bcd0), 32'h0321);
        conv0(12'd58, 16'h0058, 3'd2, 1'b0);

        iv0 = 1; ib0 = 12'd2048;
        tick();
        iv0 = 0;
        tick();
        tick();
        tick();
        rst = 1;
        chk("mid_rst_no_valid", 32'(ov0), 0);
        tick();
        chk("mid_rst_in_ready", 32'(ir0), 0);
        chk("mid_rst_bcd", 32'(bcd0), 0);
        chk("mid_rst_ndig", 32'(nd0), 1);
        rst = 0;
        tick();
        chk("mid_rel_in_ready", 32'(ir0), 1);
        n = 0;
        for (int i = 0; i < 15; i++) begin
            if (ov0) n++;
            tick();
        end
        chk("mid_rst_no_pulse", n, 0);
        conv0(12'd2048, 16'h2048, 3'd4, 1'b0);

        conv1(12'd1234, 12'h999, 2'd3, 1'b1);
        conv1(12'd999,  12'h999, 2'd3, 1'b0);

        conv2(16'd65535, 20'h65535, 3'd5);
        conv2(16'd10000, 20'h10000, 3'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
